// File: rtl/fdiv_mul_post.sv
// fdiv_mul_post: dividend delay line plus a two-stage single-precision
// multiplier that forms a/b as a * (1/b). The reciprocal 1/b comes from an
// upstream unit with FINV_LAT cycles of latency.
module fdiv_mul_post #(
  parameter int FINV_LAT = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [31:0] a,
  input  logic [31:0] inv,
  output logic [31:0] y,
  output logic        out_valid
);

  // Dividend delay line, D1 at index 0, D_FINV_LAT at index FINV_LAT-1
  logic [31:0] d_a [FINV_LAT];
  logic        d_v [FINV_LAT];

  // Shift the dividend and its valid bit; flush kills every valid in flight
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < FINV_LAT; i++) begin
        d_a[i] <= 32'd0;
        d_v[i] <= 1'b0;
      end
    end else begin
      d_a[0] <= a;
      d_v[0] <= in_valid & ~flush;
      for (int i = 1; i < FINV_LAT; i++) begin
        d_a[i] <= d_a[i-1];
        d_v[i] <= d_v[i-1] & ~flush;
      end
    end
  end

  // Operand fields at the point where the delayed dividend meets 1/b
  logic [31:0]       tap;
  logic [7:0]        tap_e;
  logic [7:0]        inv_e;
  logic [47:0]       prod_c;
  logic signed [9:0] esum_c;

  assign tap    = d_a[FINV_LAT-1];
  assign tap_e  = tap[30:23];
  assign inv_e  = inv[30:23];
  assign prod_c = 48'({1'b1, tap[22:0]}) * 48'({1'b1, inv[22:0]});
  assign esum_c = $signed({2'b00, tap_e}) + $signed({2'b00, inv_e});

  // M1 stage registers
  logic              m1_v;
  logic              m1_s;
  logic [47:0]       m1_prod;
  logic signed [9:0] m1_esum;
  logic              m1_zero;
  logic              m1_inf;

  // M1: sign, mantissa product, exponent sum and special-operand flags
  always_ff @(posedge clk) begin
    if (!rstn) begin
      m1_v    <= 1'b0;
      m1_s    <= 1'b0;
      m1_prod <= 48'd0;
      m1_esum <= 10'sd0;
      m1_zero <= 1'b0;
      m1_inf  <= 1'b0;
    end else begin
      m1_v    <= d_v[FINV_LAT-1] & ~flush;
      m1_s    <= tap[31] ^ inv[31];
      m1_prod <= prod_c;
      m1_esum <= esum_c;
      m1_zero <= (tap_e == 8'd0) || (inv_e == 8'd0);
      m1_inf  <= (tap_e == 8'hFF) || (inv_e == 8'hFF);
    end
  end

  // M2 combinational normalize / round / special-case result
  logic [22:0]       mant_c;
  logic              rbit_c;
  logic signed [9:0] exp_n;
  logic [23:0]       mant_rnd;
  logic signed [9:0] exp_f;
  logic [31:0]       y_c;

  // Normalize on product bit 47, round half-up, then apply zero/inf/range rules
  always_comb begin
    mant_c   = m1_prod[45:23];
    rbit_c   = m1_prod[22];
    exp_n    = m1_esum - 10'sd127;
    if (m1_prod[47]) begin
      mant_c = m1_prod[46:24];
      rbit_c = m1_prod[23];
      exp_n  = m1_esum - 10'sd126;
    end
    mant_rnd = {1'b0, mant_c} + {23'd0, rbit_c};
    // A carry out leaves the low 23 bits at zero and bumps the exponent
    exp_f    = exp_n + (mant_rnd[23] ? 10'sd1 : 10'sd0);
    y_c      = {m1_s, exp_f[7:0], mant_rnd[22:0]};
    if (m1_zero) begin
      y_c = {m1_s, 31'd0};
    end else if (m1_inf) begin
      y_c = {m1_s, 8'hFF, 23'd0};
    end else if (exp_f >= 10'sd255) begin
      y_c = {m1_s, 8'hFF, 23'd0};
    end else if (exp_f <= 10'sd0) begin
      y_c = {m1_s, 31'd0};
    end
  end

  // M2: register the quotient and its valid flag
  always_ff @(posedge clk) begin
    if (!rstn) begin
      y         <= 32'd0;
      out_valid <= 1'b0;
    end else begin
      y         <= y_c;
      out_valid <= m1_v & ~flush;
    end
  end

endmodule
